step_sequencer: RTL

Drum-pattern step sequencer sitting directly downstream of the Avalon-MM pattern RAM controller: it consumes the 32-bit `pattern` word (RAM word 0, read continuously on port B) and walks it as 4 tracks × 8 steps at a programmable tempo. On each step it emits a per-track trigger vector to the sound-generation stage over a valid/ready handshake. Runs on the 50 MHz system clock.

---
 rtl/step_sequencer_if.sv | 10 +
 rtl/step_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/step_sequencer_if.sv
// Trigger handshake between the step sequencer and the sound-generation stage.
// The sequencer drives TRIG/TRIG_VALID; the consumer drives TRIG_READY.
interface step_sequencer_if;
    logic [3:0] TRIG;
    logic       TRIG_VALID;
    logic       TRIG_READY;

    modport master (output TRIG, output TRIG_VALID, input TRIG_READY);
    modport slave  (input TRIG, input TRIG_VALID, output TRIG_READY);
endinterface

// File: rtl/step_sequencer.sv
// 4-track x 8-step drum sequencer: walks the 32-bit pattern word at a programmable tempo.
// Optional swing timing is compiled in when SEQ_SWING_EN is defined.
module step_sequencer #(
    parameter int PERIOD_W   = 26,
    parameter int MIN_PERIOD = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         pattern,
    input  logic                RUN,
    input  logic [PERIOD_W-1:0] STEP_PERIOD,
    input  logic                SWING,
    step_sequencer_if.master    trig,
    output logic [2:0]          STEP,
    output logic                OVERRUN
);

    localparam int CW = PERIOD_W + 1;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  limit_q, limit_d;
    logic [2:0]     step_q, step_d;
    logic [31:0]    pat_q, pat_d;
    logic [3:0]     trig_q, trig_d;
    logic           valid_q, valid_d;
    logic           ovr_q, ovr_d;

    logic [PERIOD_W-1:0] period_eff;
    logic [CW-1:0]       base;
    logic [CW-1:0]       limit_n;
    logic [2:0]          step_n;
    logic [31:0]         pat_src;
    logic [3:0]          col;
    logic                fire;

    assign period_eff = (STEP_PERIOD < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : STEP_PERIOD;
    assign base       = {1'b0, period_eff};

    // The step about to fire, and the word it reads: a fresh snapshot at start and at bar wrap.
    assign step_n  = (state_q == IDLE) ? 3'd0 : step_q + 3'd1;
    assign pat_src = (state_q == IDLE || step_q == 3'd7) ? pattern : pat_q;

`ifdef SEQ_SWING_EN
    logic [CW-1:0] quarter;
    assign quarter = {3'b000, period_eff[PERIOD_W-1:2]};
    // Interval that follows step_n: long after even steps, short after odd ones.
    assign limit_n = !SWING     ? base - CW'(1) :
                     step_n[0]  ? base - quarter - CW'(1) :
                                  base + quarter - CW'(1);
`else
    logic unused_swing;
    assign unused_swing = SWING;
    assign limit_n      = base - CW'(1);
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] row;
        assign row     = pat_src[gi*8 +: 8];
        assign col[gi] = row[step_n];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        step_d  = step_q;
        pat_d   = pat_q;
        trig_d  = trig_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RUN) begin
                    state_d = PLAY;
                    pat_d   = pattern;
                    cnt_d   = '0;
                    step_d  = 3'd0;
                    limit_d = limit_n;
                    fire    = 1'b1;
                end
            end
            PLAY: begin
                if (!RUN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = 3'd0;
                    valid_d = 1'b0;
                    ovr_d   = 1'b0;
                end else begin
                    if (valid_q && trig.TRIG_READY) valid_d = 1'b0;
                    if (cnt_q == limit_q) begin
                        cnt_d   = '0;
                        step_d  = step_n;
                        limit_d = limit_n;
                        fire    = 1'b1;
                        if (step_q == 3'd7) pat_d = pattern;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A silent column leaves any pending trigger untouched; a new hit wins over acceptance.
        if (fire && col != 4'd0) begin
            trig_d  = col;
            valid_d = 1'b1;
            if (valid_q && !trig.TRIG_READY) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            step_q  <= 3'd0;
            pat_q   <= '0;
            trig_q  <= 4'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            step_q  <= step_d;
            pat_q   <= pat_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign trig.TRIG       = trig_q;
    assign trig.TRIG_VALID = valid_q;
    assign STEP            = step_q;
    assign OVERRUN         = ovr_q;

endmodule
